// File: rtl/fp_add_pkg.sv
// Shared definitions for the pipelined single-precision FP adder:
// field widths, special encodings, flag bit positions and pack-path selection.
package fp_add_pkg;

  localparam int unsigned EXP_W  = 8;
  localparam int unsigned FRAC_W = 23;
  localparam int unsigned MANT_W = FRAC_W + 1;
  localparam int unsigned WORD_W = 1 + EXP_W + FRAC_W;

  localparam logic [EXP_W-1:0]  EXP_MAX = 8'hFF;
  localparam logic [WORD_W-1:0] QNAN    = 32'h7FC00000;

  localparam int unsigned FLG_INV = 3;
  localparam int unsigned FLG_OVF = 2;
  localparam int unsigned FLG_UNF = 1;
  localparam int unsigned FLG_INX = 0;

  typedef struct packed {
    logic              sign;
    logic [EXP_W-1:0]  exp;
    logic [FRAC_W-1:0] frac;
  } fp32_t;

  typedef enum logic [1:0] {
    PK_NAN,
    PK_INF,
    PK_ZERO,
    PK_FIN
  } pack_sel_e;

  // Special-case priority: nan > inf > zero > finite.
  function automatic pack_sel_e pack_select(input logic is_nan,
                                            input logic is_inf,
                                            input logic is_zero);
    if (is_nan)       return PK_NAN;
    else if (is_inf)  return PK_INF;
    else if (is_zero) return PK_ZERO;
    else              return PK_FIN;
  endfunction

endpackage

// File: rtl/fp_skid_buf.sv
// Valid/ready output register with optional second (skid) entry so that the
// upstream ready can be registered without losing throughput.
module fp_skid_buf #(
  parameter int unsigned WIDTH   = 36,
  parameter bit          SKID_EN = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [WIDTH-1:0] in_data_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [WIDTH-1:0] out_data_o
);

  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] out_data_q,  out_data_d;
  logic             xfer;
  logic             accept;

  assign xfer = out_valid_q & out_ready_i;

  generate
    if (SKID_EN) begin : g_skid
      logic             skid_valid_q, skid_valid_d;
      logic [WIDTH-1:0] skid_data_q,  skid_data_d;

      assign in_ready_o = !skid_valid_q;
      assign accept     = in_valid_i & !skid_valid_q;

      // With the skid full, in_ready is low, so accept and skid drain never coincide.
      always_comb begin
        out_valid_d  = out_valid_q;
        out_data_d   = out_data_q;
        skid_valid_d = skid_valid_q;
        skid_data_d  = skid_data_q;
        if (xfer) begin
          if (skid_valid_q) begin
            out_data_d   = skid_data_q;
            skid_valid_d = 1'b0;
          end else if (accept) begin
            out_data_d = in_data_i;
          end else begin
            out_valid_d = 1'b0;
          end
        end else if (accept) begin
          if (out_valid_q) begin
            skid_valid_d = 1'b1;
            skid_data_d  = in_data_i;
          end else begin
            out_valid_d = 1'b1;
            out_data_d  = in_data_i;
          end
        end
      end

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          skid_valid_q <= 1'b0;
          skid_data_q  <= '0;
        end else begin
          skid_valid_q <= skid_valid_d;
          skid_data_q  <= skid_data_d;
        end
      end
    end else begin : g_single
      assign in_ready_o = !out_valid_q | out_ready_i;
      assign accept     = in_valid_i & in_ready_o;

      always_comb begin
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        if (accept) begin
          out_valid_d = 1'b1;
          out_data_d  = in_data_i;
        end else if (xfer) begin
          out_valid_d = 1'b0;
        end
      end
    end
  endgenerate

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
    end
  end

  assign out_valid_o = out_valid_q;
  assign out_data_o  = out_data_q;

endmodule

// File: rtl/fp_add_result_pack.sv
// Final FP adder stage: rounding-carry exponent adjust, overflow detection,
// IEEE-754 single packing, registered valid/ready output and sticky flags.
module fp_add_result_pack
  import fp_add_pkg::*;
#(
  parameter int unsigned FLAG_W  = 4,
  parameter bit          SKID_EN = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              in_sign,
  input  logic [EXP_W-1:0]  in_exp,
  input  logic [MANT_W-1:0] in_mant,
  input  logic              in_ovf_rnd,
  input  logic              in_is_nan,
  input  logic              in_is_inf,
  input  logic              in_is_zero,
  input  logic              in_invalid,
  input  logic              in_inexact,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [WORD_W-1:0] out_result,
  output logic [FLAG_W-1:0] out_flags,
  output logic [FLAG_W-1:0] sticky_flags,
  input  logic              clr_flags
);

  fp32_t             pk_res;
  logic [FLAG_W-1:0] pk_flags;
  logic [EXP_W:0]    e9;
  pack_sel_e         sel;

  always_comb begin
    pk_res   = '0;
    pk_flags = '0;
    e9       = {1'b0, in_exp} + {{EXP_W{1'b0}}, in_ovf_rnd};
    sel      = pack_select(in_is_nan, in_is_inf, in_is_zero);
    pk_flags[FLG_INV] = in_invalid;
    case (sel)
      PK_NAN:  pk_res = fp32_t'(QNAN);
      PK_INF: begin
        pk_res.sign = in_sign;
        pk_res.exp  = EXP_MAX;
      end
      PK_ZERO: pk_res.sign = in_sign;
      default: begin
        pk_res.sign = in_sign;
        if (e9 >= {1'b0, EXP_MAX}) begin
          pk_res.exp        = EXP_MAX;
          pk_flags[FLG_OVF] = 1'b1;
          pk_flags[FLG_INX] = 1'b1;
        end else begin
          // Subnormal input: hidden bit set means rounding reached min normal.
          if (in_exp == '0 && !in_ovf_rnd)
            pk_res.exp = {{(EXP_W-1){1'b0}}, in_mant[MANT_W-1]};
          else
            pk_res.exp = e9[EXP_W-1:0];
          pk_res.frac       = in_ovf_rnd ? '0 : in_mant[FRAC_W-1:0];
          pk_flags[FLG_UNF] = (pk_res.exp == '0) & in_inexact;
          pk_flags[FLG_INX] = in_inexact;
        end
      end
    endcase
  end

  logic [FLAG_W+WORD_W-1:0] buf_out;

  fp_skid_buf #(
    .WIDTH  (FLAG_W + WORD_W),
    .SKID_EN(SKID_EN)
  ) u_skid (
    .clk        (clk),
    .rst        (rst),
    .in_valid_i (in_valid),
    .in_ready_o (in_ready),
    .in_data_i  ({pk_flags, pk_res}),
    .out_valid_o(out_valid),
    .out_ready_i(out_ready),
    .out_data_o (buf_out)
  );

  assign out_flags  = buf_out[FLAG_W+WORD_W-1:WORD_W];
  assign out_result = buf_out[WORD_W-1:0];

  logic [FLAG_W-1:0] sticky_q, sticky_d;

  always_comb begin
    sticky_d = clr_flags ? '0 : sticky_q;
    if (out_valid && out_ready)
      sticky_d = sticky_d | out_flags;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) sticky_q <= '0;
    else     sticky_q <= sticky_d;
  end

  assign sticky_flags = sticky_q;

endmodule

// File: tb/tb_fp_add_result_pack.sv
// Bench for fp_add_result_pack: directed cases plus randomized traffic
// scored against a queue-based reference of the packing rules.
module tb_fp_add_result_pack;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_ready;
  logic        in_sign;
  logic [7:0]  in_exp;
  logic [23:0] in_mant;
  logic        in_ovf_rnd, in_is_nan, in_is_inf, in_is_zero, in_invalid, in_inexact;
  logic        out_valid, out_ready;
  logic [31:0] out_result;
  logic [3:0]  out_flags, sticky_flags;
  logic        clr_flags;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  logic [35:0] exp_q[$];
  logic [3:0]  sticky_exp;
  bit          prev_stall;
  logic [35:0] prev_word;

  always #5 clk = ~clk;

  fp_add_result_pack #(.FLAG_W(4), .SKID_EN(1'b1)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_sign(in_sign), .in_exp(in_exp), .in_mant(in_mant),
    .in_ovf_rnd(in_ovf_rnd), .in_is_nan(in_is_nan), .in_is_inf(in_is_inf),
    .in_is_zero(in_is_zero), .in_invalid(in_invalid), .in_inexact(in_inexact),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_result(out_result), .out_flags(out_flags),
    .sticky_flags(sticky_flags), .clr_flags(clr_flags)
  );

  task automatic check_eq(input string tag, input logic [35:0] act, input logic [35:0] expv);
    n_checks++;
    if (act !== expv) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, act, expv);
    end
  endtask

  // Reference: {flags[3:0], word[31:0]} from the value-level rules.
  function automatic logic [35:0] ref_pack(input bit s, input int unsigned e, input int unsigned m,
                                           input bit ovf, input bit nan, input bit inf,
                                           input bit zero, input bit inv, input bit inx);
    int unsigned biased, efield, frac;
    bit unf;
    if (nan)  return {inv, 3'b000, 32'h7FC00000};
    if (inf)  return {inv, 3'b000, s, 8'hFF, 23'd0};
    if (zero) return {inv, 3'b000, s, 31'd0};
    biased = e + ovf;
    if (biased >= 255) return {inv, 1'b1, 1'b0, 1'b1, s, 8'hFF, 23'd0};
    frac   = ovf ? 0 : (m % (1 << 23));
    efield = (e == 0 && !ovf) ? (m >> 23) : biased;
    unf    = (efield == 0) && inx;
    return {inv, 1'b0, unf, inx, s, efield[7:0], frac[22:0]};
  endfunction

  always @(negedge clk) begin
    logic [35:0] w;
    logic [3:0]  xf;
    if (rst) begin
      exp_q.delete();
      sticky_exp = '0;
      prev_stall = 1'b0;
    end else begin
      check_eq("sticky", {32'd0, sticky_flags}, {32'd0, sticky_exp});
      if (prev_stall) begin
        check_eq("hold_valid", {35'd0, out_valid}, 36'd1);
        check_eq("hold_data", {out_flags, out_result}, prev_word);
      end
      xf = '0;
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          check_eq("spurious_out", {35'd0, out_valid}, 36'd0);
        end else begin
          w  = exp_q.pop_front();
          xf = w[35:32];
          check_eq("result", {4'd0, out_result}, {4'd0, w[31:0]});
          check_eq("flags", {32'd0, out_flags}, {32'd0, w[35:32]});
        end
      end
      sticky_exp = (clr_flags ? 4'd0 : sticky_exp) | xf;
      prev_stall = out_valid && !out_ready;
      prev_word  = {out_flags, out_result};
      if (in_valid && in_ready)
        exp_q.push_back(ref_pack(in_sign, in_exp, in_mant, in_ovf_rnd, in_is_nan,
                                 in_is_inf, in_is_zero, in_invalid, in_inexact));
    end
  end

  task automatic set_in(input bit s, input logic [7:0] e, input logic [23:0] m, input bit ovf,
                        input bit nan, input bit inf, input bit zero, input bit inv, input bit inx);
    in_sign = s; in_exp = e; in_mant = m; in_ovf_rnd = ovf;
    in_is_nan = nan; in_is_inf = inf; in_is_zero = zero;
    in_invalid = inv; in_inexact = inx;
  endtask

  // Presents the current inputs for one accept, then checks the emitted word.
  task automatic send_chk(input string tag, input logic [31:0] er, input logic [3:0] ef);
    int unsigned waited = 0;
    @(posedge clk); #1;
    in_valid = 1'b1; out_ready = 1'b1;
    @(negedge clk);
    while (!in_ready && waited < 20) begin
      waited++;
      @(negedge clk);
    end
    if (!in_ready) check_eq({tag, "_accept_timeout"}, {35'd0, in_ready}, 36'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(negedge clk);
    check_eq({tag, "_valid"}, {35'd0, out_valid}, 36'd1);
    check_eq({tag, "_res"}, {4'd0, out_result}, {4'd0, er});
    check_eq({tag, "_flg"}, {32'd0, out_flags}, {32'd0, ef});
  endtask

  task automatic rand_fields();
    int unsigned sel;
    logic [7:0] e;
    sel = $urandom_range(0, 7);
    case (sel)
      0: e = 8'h00;
      1: e = 8'h01;
      2: e = 8'hFE;
      3: e = 8'hFF;
      default: e = 8'($urandom);
    endcase
    in_is_nan  = ($urandom_range(0, 15) == 0);
    in_invalid = in_is_nan && $urandom_range(0, 1);
    set_in(1'($urandom), e, 24'($urandom), ($urandom_range(0, 3) == 0), in_is_nan,
           ($urandom_range(0, 15) == 0), ($urandom_range(0, 15) == 0), in_invalid,
           1'($urandom));
  endtask

  initial begin
    bit acc;
    int unsigned guard;
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; clr_flags = 1'b0;
    set_in(0, 0, 0, 0, 0, 0, 0, 0, 0);
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check_eq("rst_out_valid", {35'd0, out_valid}, 36'd0);
    check_eq("rst_in_ready", {35'd0, in_ready}, 36'd1);
    check_eq("rst_out_result", {4'd0, out_result}, 36'd0);
    check_eq("rst_flags", {28'd0, out_flags, sticky_flags}, 36'd0);

    set_in(0, 8'h7F, 24'hC00000, 0, 0, 0, 0, 0, 0); send_chk("d_norm", 32'h3FC00000, 4'b0000);
    set_in(0, 8'h7F, 24'h000000, 1, 0, 0, 0, 0, 1); send_chk("d_rcarry", 32'h40000000, 4'b0001);
    set_in(1, 8'hFE, 24'hFFFFFF, 1, 0, 0, 0, 0, 0); send_chk("d_ovf", 32'hFF800000, 4'b0101);
    @(posedge clk); #1 clr_flags = 1'b1;
    @(negedge clk); check_eq("d_sticky_set", {32'd0, sticky_flags}, 36'b0101);
    @(posedge clk); #1 clr_flags = 1'b0;
    @(negedge clk); check_eq("d_sticky_clr", {32'd0, sticky_flags}, 36'd0);
    set_in(0, 8'h00, 24'h400000, 0, 0, 0, 0, 0, 1); send_chk("d_subn", 32'h00400000, 4'b0011);
    set_in(0, 8'h00, 24'h800000, 0, 0, 0, 0, 0, 0); send_chk("d_minnorm", 32'h00800000, 4'b0000);
    set_in(1, 8'h12, 24'h123456, 0, 1, 1, 0, 1, 0); send_chk("d_nan", 32'h7FC00000, 4'b1000);
    set_in(1, 8'h12, 24'h123456, 0, 0, 1, 0, 0, 0); send_chk("d_inf", 32'hFF800000, 4'b0000);
    set_in(1, 8'h00, 24'h000000, 0, 0, 0, 0, 0, 0); send_chk("d_pzero", 32'h80000000, 4'b0000);

    // Backpressure: A and B fill output+skid, C waits until the skid drains.
    @(posedge clk); #1 out_ready = 1'b0; in_valid = 1'b1;
    set_in(0, 8'h7F, 24'hC00000, 0, 0, 0, 0, 0, 0);
    @(negedge clk); check_eq("bp_accA", {35'd0, in_ready}, 36'd1);
    @(posedge clk); #1 set_in(0, 8'h80, 24'h800000, 0, 0, 0, 0, 0, 0);
    @(negedge clk); check_eq("bp_accB", {35'd0, in_ready}, 36'd1);
    @(posedge clk); #1 set_in(0, 8'h81, 24'hA00000, 0, 0, 0, 0, 0, 0);
    @(negedge clk); check_eq("bp_fullC", {35'd0, in_ready}, 36'd0);
    @(posedge clk); #1;
    @(negedge clk); check_eq("bp_stillfull", {35'd0, in_ready}, 36'd0);
    @(posedge clk); #1 out_ready = 1'b1;
    @(negedge clk); check_eq("bp_outA", {3'd0, out_valid, out_result}, {4'd1, 32'h3FC00000});
    @(posedge clk); #1;
    @(negedge clk); check_eq("bp_outB", {3'd0, out_valid, out_result}, {4'd1, 32'h40000000});
    check_eq("bp_accC", {35'd0, in_ready}, 36'd1);
    @(posedge clk); #1 in_valid = 1'b0;
    @(negedge clk); check_eq("bp_outC", {3'd0, out_valid, out_result}, {4'd1, 32'h40A00000});

    // Reset while stalled discards both held entries.
    @(posedge clk); #1 out_ready = 1'b0; in_valid = 1'b1;
    @(posedge clk); #1 set_in(1, 8'h10, 24'h812345, 0, 0, 0, 0, 0, 1);
    @(posedge clk); #1 in_valid = 1'b0; rst = 1'b1;
    @(negedge clk); check_eq("rst_stall_ov", {35'd0, out_valid}, 36'd0);
    @(posedge clk); #1 rst = 1'b0; out_ready = 1'b1;
    repeat (4) begin
      @(negedge clk); check_eq("post_rst_empty", {35'd0, out_valid}, 36'd0);
    end

    acc = 1'b1;
    repeat (600) begin
      @(posedge clk); #1;
      if (!in_valid || acc) begin
        in_valid = ($urandom_range(0, 3) != 0);
        rand_fields();
      end
      out_ready = ($urandom_range(0, 9) < 7);
      clr_flags = ($urandom_range(0, 31) == 0);
      @(negedge clk);
      acc = in_ready;
    end
    @(posedge clk); #1 in_valid = 1'b0; out_ready = 1'b1; clr_flags = 1'b0;
    guard = 0;
    while ((exp_q.size() != 0 || out_valid) && guard < 50) begin
      guard++;
      @(negedge clk);
    end
    check_eq("drain", 36'(exp_q.size()), 36'd0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/fp_add_result_pack.md
Name: fp_add_result_pack

Overview:
Final stage of the pipelined FP adder. It consumes the selected rounded mantissa and rounding carry from the rounding-select mux, together with the sign, the pre-round exponent and the special-case flags. It applies the rounding-carry exponent adjust, detects overflow and packs the IEEE-754 single-precision word. Results leave through a valid/ready output register with a skid buffer; exception flags are accumulated in sticky registers.

Parameters:
FLAG_W, 4, number of exception flag bits {invalid, overflow, underflow, inexact}
SKID_EN, 1, 1 = two-entry skid buffer (full throughput); 0 = single register (in_ready = !out_valid | out_ready)

Ports:
clk  in  1  clock
rst  in  1  asynchronous active-high reset
in_valid  in  1  upstream result valid
in_ready  out  1  stage can accept this cycle
in_sign  in  1  result sign
in_exp  in  8  biased exponent before rounding carry
in_mant  in  24  rounded mantissa incl. hidden bit (Mout)
in_ovf_rnd  in  1  rounding carry-out (ovf_rnd)
in_is_nan  in  1  result is NaN
in_is_inf  in  1  result is infinity (operand inf)
in_is_zero  in  1  exact zero result
in_invalid  in  1  invalid operation (inf - inf, sNaN)
in_inexact  in  1  rounding discarded nonzero bits
out_valid  out  1  result word valid
out_ready  in  1  downstream accepts
out_result  out  32  packed single-precision result
out_flags  out  4  per-result flags {invalid, overflow, underflow, inexact}
sticky_flags  out  4  OR of out_flags over all completed transfers
clr_flags  in  1  synchronous clear of sticky_flags

Behaviour:
- Reset (async, rst=1): out_valid=0, in_ready=1 (after release), out_result=0, out_flags=0, sticky_flags=0, skid empty. Reset mid-transfer discards all held data.
- Handshake: an input is accepted when in_valid&in_ready; an output transfers when out_valid&out_ready. out_result/out_flags stay stable while out_valid&!out_ready.
- Latency: 1 cycle from acceptance to out_valid when the output register is empty. Order is preserved. There is no loss and no duplication.
- Skid (SKID_EN=1): in_ready = !skid_full, registered. An input that is accepted while the output register is full and stalled goes into the skid. On the next output transfer the skid moves to the output register. Simultaneous accept and transfer with an empty skid loads the output register directly.
- Pack priority: nan > inf > zero > finite.
  - NaN: 0x7FC00000 (sign ignored); invalid = in_invalid.
  - Inf: {in_sign, 0xFF, 0}.
  - Zero: {in_sign, 0, 0}.
- Finite: e9 = {0,in_exp} + in_ovf_rnd.
  - in_ovf_rnd=1: fraction = 0 (mantissa rounded to 2.0, renormalised).
  - in_ovf_rnd=0: fraction = in_mant[22:0].
  - in_exp==0 & !in_ovf_rnd: exponent field = in_mant[23] (subnormal rounded up to min normal gives 1, else 0).
  - e9 >= 255: result {in_sign, 0xFF, 0}; overflow=1, inexact=1.
  - Underflow = (exponent field 0) & in_inexact.
- inexact = in_inexact | overflow. All flags are 0 for NaN/inf/zero except invalid.
- Sticky: on each output transfer, sticky |= out_flags. With clr_flags, the next value is 0 | (transfer flags if transferring that cycle).
- in_valid with no flags asserted and in_exp=0, in_mant=0 packs to ±0 (no special path needed).

Decomposition:
- Shared package fp_add_pkg:
  - EXP_MAX = 8'hFF
  - QNAN = 32'h7FC00000
  - flag bit indices FLG_INV=3, FLG_OVF=2, FLG_UNF=1, FLG_INX=0
  - packed-result field widths
- Sub-module fp_skid_buf (WIDTH parameter, valid/ready in/out, async active-high rst) holds {result, flags}.
- Pack logic is combinational in the top level.

Test Plan:
- sign0 exp=0x7F mant=0xC00000 ovf=0, out_ready=1 -> next cycle out_result=0x3FC00000, flags=0.
- exp=0x7F mant=0x000000 ovf=1 inexact=1 -> 0x40000000, flags=0001.
- sign1 exp=0xFE ovf=1 -> 0xFF800000, flags=0101, sticky=0101; then clr_flags=1 alone -> sticky=0000.
- exp=0 mant=0x400000 inexact=1 -> 0x00400000, flags=0011; exp=0 mant=0x800000 -> 0x00800000, flags=0.
- Priority: is_nan=1, is_inf=1, invalid=1 -> 0x7FC00000, flags=1000; is_inf=1, sign=1 -> 0xFF800000.
- Backpressure: out_ready=0, three back-to-back inputs A,B,C -> A,B accepted, in_ready=0 while C waits; raise out_ready -> A,B,C emitted in order, one per cycle. Pulse rst mid-stall -> out_valid=0 immediately, nothing emitted afterwards.
